// File: rtl/dso_pkg.sv
// Shared constants and types for the scope digital core.
package dso_pkg;

  localparam logic [2:0] SS_TRIG = 3'b000;
  localparam logic [2:0] SS_CH1  = 3'b001;
  localparam logic [2:0] SS_CH2  = 3'b010;
  localparam logic [2:0] SS_CH3  = 3'b011;
  localparam logic [2:0] SS_EEP  = 3'b100;

  localparam int unsigned GuardDefault = 4;
  localparam int unsigned TmoDefault   = 4096;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StGuard
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping upward.
module rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          valid
);

  logic [PW:0] sum;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // ptr < N and i < N, so one subtraction gives the modulo
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      if (!valid && req[sum[PW-1:0]]) begin
        gnt[sum[PW-1:0]] = 1'b1;
        idx              = sum[PW-1:0];
        valid            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI master among NREQ requesters, with timeout and guard gap.
module spi_arb
  import dso_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned GUARD = GuardDefault,
  parameter int unsigned TMO   = TmoDefault,
  parameter int unsigned TW    = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_data,
  input  logic [3*NREQ-1:0]    req_ss,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic                 wrt_SPI,
  output logic [15:0]          SPI_data,
  output logic [2:0]           ss,
  input  logic                 SPI_done,
  input  logic [7:0]           EEP_data,
  output logic                 busy
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic            err_q, err_d, wrt_q, wrt_d, busy_q, busy_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [15:0]     spi_data_q, spi_data_d;
  logic [2:0]      ss_q, ss_d;
  logic [PW-1:0]   ptr_q, ptr_d, idx_q, idx_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    err_d      = 1'b0;
    wrt_d      = 1'b0;
    rdata_d    = rdata_q;
    spi_data_d = spi_data_q;
    ss_d       = ss_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    tcnt_d     = tcnt_q;
    gcnt_d     = gcnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d = pick_gnt;
          idx_d = pick_idx;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
              spi_data_d = req_data[16*i +: 16];
              ss_d       = req_ss[3*i +: 3];
            end
          end
          state_d = StStart;
        end
      end
      StStart: begin
        wrt_d   = 1'b1;
        tcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        tcnt_d = tcnt_q + 1'b1;
        // SPI_done wins over a simultaneous timeout
        if (SPI_done) begin
          rdata_d = EEP_data;
          done_d  = gnt_q;
          gcnt_d  = '0;
          state_d = StGuard;
        end else if (tcnt_q == TW'(TMO - 1)) begin
          done_d  = gnt_q;
          err_d   = 1'b1;
          gcnt_d  = '0;
          state_d = StGuard;
        end
      end
      StGuard: begin
        // gnt stays up through the done cycle, drops on the first GUARD edge
        gnt_d = '0;
        ptr_d = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        if (gcnt_q == GW'(GUARD)) begin
          state_d = StIdle;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      wrt_q      <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      spi_data_q <= '0;
      ss_q       <= '0;
      ptr_q      <= '0;
      idx_q      <= '0;
      tcnt_q     <= '0;
      gcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wrt_q      <= wrt_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      spi_data_q <= spi_data_d;
      ss_q       <= ss_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      tcnt_q     <= tcnt_d;
      gcnt_q     <= gcnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign wrt_SPI  = wrt_q;
  assign busy     = busy_q;
  assign rdata    = rdata_q;
  assign SPI_data = spi_data_q;
  assign ss       = ss_q;

endmodule

// File: tb/tb_spi_arb.sv
// Scoreboard bench for spi_arb: expected transactions queued at stimulus, checked at wrt_SPI/done.
module tb_spi_arb;

  localparam int NREQ  = 3;
  localparam int GUARD = 4;
  localparam int TMO   = 4096;

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic [2:0]  ss;
    logic [7:0]  rdata;
    logic        err;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [16*NREQ-1:0]  req_data;
  logic [3*NREQ-1:0]   req_ss;
  logic [NREQ-1:0]     gnt, done;
  logic                err, wrt_SPI, SPI_done, busy;
  logic [7:0]          rdata, EEP_data;
  logic [15:0]         SPI_data;
  logic [2:0]          ss;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   sd_cyc = 0;

  spi_arb #(
    .NREQ  (NREQ),
    .GUARD (GUARD),
    .TMO   (TMO),
    .TW    (13)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .req_ss   (req_ss),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .wrt_SPI  (wrt_SPI),
    .SPI_data (SPI_data),
    .ss       (ss),
    .SPI_done (SPI_done),
    .EEP_data (EEP_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [7:0] rd, input logic e);
    exp_t x;
    x.idx   = idx;
    x.data  = req_data[16*idx +: 16];
    x.ss    = req_ss[3*idx +: 3];
    x.rdata = rd;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  // Waits for wrt_SPI, answers after delay cycles (delay < 0: never), waits for done.
  task automatic respond(input int delay, input logic [7:0] eep, output int wcyc, output int lat);
    int n;
    lat  = -1;
    wcyc = -1;
    n    = 0;
    while (!wrt_SPI && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!wrt_SPI) begin
      check_eq("wrt_wait", 32'(0), 32'(1));
      return;
    end
    wcyc = cyc;
    if (delay >= 0) begin
      repeat (delay) @(negedge clk);
      SPI_done = 1'b1;
      EEP_data = eep;
      sd_cyc   = cyc;
      @(negedge clk);
      SPI_done = 1'b0;
    end
    n = 0;
    while (done == '0 && n < TMO + 50) begin
      @(negedge clk);
      n++;
    end
    if (done == '0) check_eq("done_wait", 32'(0), 32'(1));
    else lat = cyc - wcyc;
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_gnt"}, gnt, 0);
    check_eq({pfx, "_done"}, done, 0);
    check_eq({pfx, "_err"}, err, 0);
    check_eq({pfx, "_rdata"}, rdata, 0);
    check_eq({pfx, "_wrt"}, wrt_SPI, 0);
    check_eq({pfx, "_data"}, SPI_data, 0);
    check_eq({pfx, "_ss"}, ss, 0);
    check_eq({pfx, "_busy"}, busy, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wrt_SPI) begin
        if (exp_q.size() == 0) begin
          check_eq("wrt_unexpected", 32'(1), 32'(0));
        end else begin
          check_eq("spi_data", SPI_data, exp_q[0].data);
          check_eq("spi_ss", ss, exp_q[0].ss);
          check_eq("gnt_at_wrt", gnt, 32'(1) << exp_q[0].idx);
        end
      end
      if (done != '0) begin
        if (exp_q.size() == 0) begin
          check_eq("done_unexpected", done, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("done_onehot", done, 32'(1) << mon_e.idx);
          check_eq("gnt_at_done", gnt, 32'(1) << mon_e.idx);
          check_eq("err", err, mon_e.err);
          check_eq("rdata", rdata, mon_e.rdata);
        end
      end else if (err) begin
        check_eq("err_without_done", err, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc, lat, n, prev_sd;
    rst = 1'b1; req = '0; req_data = '0; req_ss = '0; SPI_done = 1'b0; EEP_data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single request
    req_data[15:0] = 16'hA5C3;
    req_ss[2:0]    = 3'b001;
    req            = 3'b001;
    push_exp(0, 8'h5A, 1'b0);
    @(negedge clk);
    check_eq("t1_gnt", gnt, 3'b001);
    check_eq("t1_wrt_early", wrt_SPI, 0);
    @(negedge clk);
    check_eq("t1_wrt", wrt_SPI, 1);
    respond(20, 8'h5A, wc, lat);
    check_eq("t1_lat", lat, 21);
    req = '0;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("t1_busy_lat", n, GUARD + 1);

    // Stray SPI_done in IDLE
    SPI_done = 1'b1;
    EEP_data = 8'hFF;
    @(negedge clk);
    SPI_done = 1'b0;
    check_eq("stray_rdata", rdata, 8'h5A);
    check_eq("stray_done", done, 0);
    check_eq("stray_err", err, 0);
    check_eq("stray_busy", busy, 0);
    check_eq("stray_wrt", wrt_SPI, 0);
    @(negedge clk);

    // Contention from reset: grants 0,1,2,0,1,2
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_data[16*i +: 16] = 16'hC000 + 16'(i * 257);
      req_ss[3*i +: 3]     = 3'(i + 1);
    end
    req = '1;
    for (int k = 0; k < 6; k++) push_exp(k % NREQ, 8'(8'h10 + k), 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    prev_sd = 0;
    for (int k = 0; k < 6; k++) begin
      respond(3, 8'(8'h10 + k), wc, lat);
      if (k > 0) check_eq("cont_gap", 32'((wc - prev_sd) >= GUARD + 2), 32'(1));
      prev_sd = sd_cyc;
    end
    req = '0;

    // Pointer wrap after serving requester 2
    req = 3'b011;
    push_exp(0, 8'h21, 1'b0);
    push_exp(1, 8'h22, 1'b0);
    respond(5, 8'h21, wc, lat);
    respond(5, 8'h22, wc, lat);
    req = '0;

    // Timeout on requester 1; rdata keeps 22
    req = 3'b010;
    push_exp(1, 8'h22, 1'b1);
    respond(-1, 8'h00, wc, lat);
    check_eq("tmo_lat", lat, TMO);
    req = '0;

    // SPI_done coincident with timeout expiry
    req = 3'b010;
    push_exp(1, 8'h3C, 1'b0);
    respond(TMO - 1, 8'h3C, wc, lat);
    check_eq("tmo_edge_lat", lat, TMO);
    req = '0;

    // Reset mid-WAIT
    req = 3'b100;
    push_exp(2, 8'h00, 1'b0);
    n = 0;
    while (!wrt_SPI && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("rw_wrt", wrt_SPI, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check_all_zero("rw");
    repeat (10) @(negedge clk);
    check_eq("rw_busy", busy, 0);
    // From pointer 0, requester 1 wins over 2
    req = 3'b110;
    push_exp(1, 8'h44, 1'b0);
    push_exp(2, 8'h45, 1'b0);
    respond(2, 8'h44, wc, lat);
    respond(2, 8'h45, wc, lat);
    req = '0;
    repeat (10) @(negedge clk);
    check_eq("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
